// File: rtl/instr_serial_arbiter.sv
// instr_serial_arbiter: two-source instruction arbiter feeding an MSB-first serial stream.
// Define ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module instr_serial_arbiter #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    input  logic [WORD_W-1:0] instr0,
    input  logic [WORD_W-1:0] instr1,
    output logic [1:0]        req_ready,
    output logic              ser_bit,
    output logic              ser_valid,
    output logic              ser_first,
    output logic              word_done,
    output logic              grant_id,
    output logic              busy,
    output logic [CNT_W-1:0]  word_count
);
    localparam int CW = WORD_W > 1 ? $clog2(WORD_W) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORD_W - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state, state_nx;
    logic [WORD_W-1:0] shreg, shreg_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [CNT_W-1:0]  wc_nx;
    logic              gid_nx, last_word, grant_pt, grant, pick;

`ifdef ARB_FIXED_PRIO_EN
    assign pick = !req_valid[0];
`else
    // last granted requester; reset to 1 so requester 0 wins the first tie
    logic last;
    assign pick = &req_valid ? !last : req_valid[1];
    always_ff @(posedge clk)
        if (reset) last <= 1'b1;
        else if (grant) last <= pick;
`endif

    always_comb begin
        last_word = state == SHIFT && cnt == LAST;
        grant_pt  = state == IDLE || last_word;
        grant     = grant_pt && |req_valid && !reset;
        req_ready = grant ? (pick ? 2'b10 : 2'b01) : 2'b00;
        state_nx  = state;
        shreg_nx  = shreg;
        cnt_nx    = cnt;
        gid_nx    = grant_id;
        wc_nx     = word_count;
        if (state == SHIFT) begin
            shreg_nx = shreg << 1;
            cnt_nx   = cnt + 1'b1;
        end
        if (last_word) begin
            wc_nx    = word_count + 1'b1;
            state_nx = IDLE;
        end
        if (grant) begin
            shreg_nx = pick ? instr1 : instr0;
            cnt_nx   = '0;
            gid_nx   = pick;
            state_nx = SHIFT;
        end
    end

    always_ff @(posedge clk)
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            grant_id   <= 1'b0;
            word_count <= '0;
        end else begin
            state      <= state_nx;
            shreg      <= shreg_nx;
            cnt        <= cnt_nx;
            grant_id   <= gid_nx;
            word_count <= wc_nx;
        end

    assign busy      = state == SHIFT;
    assign ser_valid = busy;
    assign ser_bit   = busy & shreg[WORD_W-1];
    assign ser_first = busy && cnt == '0;
    assign word_done = last_word;
endmodule

// File: tb/tb_instr_serial_arbiter.sv
// tb_instr_serial_arbiter: queue-based reference model checked every cycle, plus literal spot checks.
module tb_instr_serial_arbiter;
    logic        clk = 0, reset = 1;
    logic [1:0]  req_valid = 0, req_ready;
    logic [31:0] instr0 = 0, instr1 = 0;
    logic        ser_bit, ser_valid, ser_first, word_done, grant_id, busy;
    logic [7:0]  word_count;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    instr_serial_arbiter dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .instr0(instr0), .instr1(instr1),
        .req_ready(req_ready), .ser_bit(ser_bit), .ser_valid(ser_valid), .ser_first(ser_first),
        .word_done(word_done), .grant_id(grant_id), .busy(busy), .word_count(word_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a queue of bits still to appear on the serial line, one entry per cycle.
    typedef struct packed {logic b; logic first; logic done; logic gid;} ent_t;
    ent_t       mq[$];
    logic       m_last = 1, m_pick, m_gp;
    logic [1:0] m_ready;
    int         m_wc = 0;

    always @(negedge clk) begin
        m_gp = mq.size() <= 1;
`ifdef ARB_FIXED_PRIO_EN
        m_pick = !req_valid[0];
`else
        m_pick = (req_valid == 2'b11) ? !m_last : req_valid[1];
`endif
        m_ready = (m_gp && req_valid != 0 && !reset) ? (m_pick ? 2'b10 : 2'b01) : 2'b00;
        chk("req_ready", 32'(req_ready), 32'(m_ready));
        chk("word_count", 32'(word_count), 32'(m_wc));
        if (mq.size() != 0) begin
            chk("ser_valid", 32'(ser_valid), 1);
            chk("busy", 32'(busy), 1);
            chk("ser_bit", 32'(ser_bit), 32'(mq[0].b));
            chk("ser_first", 32'(ser_first), 32'(mq[0].first));
            chk("word_done", 32'(word_done), 32'(mq[0].done));
            chk("grant_id", 32'(grant_id), 32'(mq[0].gid));
        end else begin
            chk("ser_valid_idle", 32'(ser_valid), 0);
            chk("busy_idle", 32'(busy), 0);
            chk("ser_bit_idle", 32'(ser_bit), 0);
            chk("ser_first_idle", 32'(ser_first), 0);
            chk("word_done_idle", 32'(word_done), 0);
        end
        if (reset) begin
            mq.delete();
            m_last = 1;
            m_wc = 0;
        end else begin
            if (mq.size() != 0) begin
                if (mq[0].done) m_wc = (m_wc + 1) % 256;
                void'(mq.pop_front());
            end
            if (m_gp && req_valid != 0) begin
                for (int i = 0; i < 32; i++)
                    mq.push_back('{b: (m_pick ? instr1[31-i] : instr0[31-i]),
                                   first: (i == 0), done: (i == 31), gid: m_pick});
                m_last = m_pick;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic capture(output logic [31:0] cap, output int nv);
        cap = 0;
        nv = 0;
        repeat (32) begin
            @(negedge clk);
            cap = {cap[30:0], ser_bit};
            nv += int'(ser_valid);
        end
    endtask

    task automatic wait_done(input int target, inout int nd);
        int c = 0;
        while (nd < target && c < 9000) begin
            @(negedge clk);
            if (word_done) nd++;
            c++;
        end
        if (nd < target) chk("timeout_word_done", 32'(nd), 32'(target));
    endtask

    logic [31:0] cap;
    logic [3:0]  gseq;
    int          nv, nf, fpos, dpos, nd;
    logic        r1seen;

    initial begin
        // reset state with a pending request: ready must stay low
        req_valid = 2'b01;
        instr0 = 32'h0800_0010;
        tick();
        tick();
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_ser_valid", 32'(ser_valid), 0);
        chk("rst_ser_bit", 32'(ser_bit), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_word_count", 32'(word_count), 0);
        tick();
        reset = 0;
        // single word
        @(negedge clk);
        chk("single_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 0;
        @(negedge clk);
        chk("single_ready_drop", 32'(req_ready), 0);
        chk("single_first", 32'(ser_first), 1);
        cap = {31'b0, ser_bit};
        nv = int'(ser_valid);
        dpos = -1;
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            cap = {cap[30:0], ser_bit};
            nv += int'(ser_valid);
            if (word_done) dpos = i;
        end
        chk("single_bits", cap, 32'h0800_0010);
        chk("single_valid_cnt", 32'(nv), 32);
        chk("single_done_pos", 32'(dpos), 31);
        @(negedge clk);
        chk("single_busy_after", 32'(busy), 0);
        chk("single_count", 32'(word_count), 1);

        // tie: alternating grants, no gaps
        do_reset();
        req_valid = 2'b11;
        instr0 = 32'h2001_0005;
        instr1 = 32'h0022_1820;
        @(negedge clk);
        r1seen = req_ready[1];
        gseq = 0;
        nv = 0;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            r1seen |= req_ready[1];
            nv += int'(ser_valid);
            if (ser_first) gseq = {gseq[2:0], grant_id};
        end
        @(negedge clk);
        chk("tie_count", 32'(word_count), 4);
        chk("tie_valid_cnt", 32'(nv), 128);
`ifdef ARB_FIXED_PRIO_EN
        chk("tie_grants", 32'(gseq), 32'h0);
        chk("tie_ready1_seen", 32'(r1seen), 0);
`else
        chk("tie_grants", 32'(gseq), 32'h5);
        chk("tie_ready1_seen", 32'(r1seen), 1);
`endif
        tick();
        req_valid = 0;
        repeat (40) tick();

        // back-to-back from a single source
        do_reset();
        req_valid = 2'b01;
        instr0 = 32'hDEAD_BEEF;
        tick();
        nv = 0;
        nf = 0;
        fpos = 0;
        for (int i = 0; i < 96; i++) begin
            @(negedge clk);
            nv += int'(ser_valid);
            if (ser_first) begin
                nf++;
                fpos += i;
            end
        end
        chk("b2b_valid_cnt", 32'(nv), 96);
        chk("b2b_first_cnt", 32'(nf), 3);
        chk("b2b_first_pos_sum", 32'(fpos), 96);
        req_valid = 0;
        repeat (40) tick();

        // reset in the middle of a word
        do_reset();
        req_valid = 2'b10;
        instr1 = 32'hA5A5_0F0F;
        tick();
        req_valid = 0;
        repeat (10) tick();
        reset = 1;
        tick();
        reset = 0;
        @(negedge clk);
        chk("midrst_valid", 32'(ser_valid), 0);
        chk("midrst_bit", 32'(ser_bit), 0);
        chk("midrst_done", 32'(word_done), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_gid", 32'(grant_id), 0);
        chk("midrst_count", 32'(word_count), 0);
        tick();
        req_valid = 2'b01;
        instr0 = 32'h1234_5678;
        tick();
        req_valid = 0;
        capture(cap, nv);
        chk("midrst_resend_bits", cap, 32'h1234_5678);
        chk("midrst_resend_valid", 32'(nv), 32);
        @(negedge clk);
        chk("midrst_resend_count", 32'(word_count), 1);

        // word_count wrap over 256 words
        do_reset();
        req_valid = 2'b01;
        instr0 = 32'h8000_0001;
        nd = 0;
        wait_done(255, nd);
        @(negedge clk);
        if (word_done) nd++;
        chk("wrap_255", 32'(word_count), 255);
        wait_done(256, nd);
        @(negedge clk);
        chk("wrap_0", 32'(word_count), 0);
        req_valid = 0;
        repeat (40) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
